sobel_control_unit: RTL and testbench
=====================================

SOBEL_CONTROL_UNIT -- requirements
Module: sobel_control_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: word address width of the shared image memory.
REQ-002 Parameter DIM_WIDTH, default 12: width of the row and column count fields.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; forces the reset state immediately.
REQ-005 go  input  1  start request, sampled only in IDLE.
REQ-006 cfg_in_base  input  ADDR_WIDTH  word address of input image row 0, chunk 0.
REQ-007 cfg_out_base  input  ADDR_WIDTH  word address of output row 0, chunk 0.
REQ-008 cfg_cols  input  DIM_WIDTH  chunks per row; one chunk is one memory word of `NUM_SOBEL_ACCELERATORS output pixels.
REQ-009 cfg_rows  input  DIM_WIDTH  input image rows.
REQ-010 mem_req  output  1  memory request valid.
REQ-011 mem_we  output  1  1 = write (data from accelerator), 0 = read.
REQ-012 mem_addr  output  ADDR_WIDTH  request word address.
REQ-013 mem_ack  input  1  completes current request; read data valid in the same cycle.
REQ-014 sctrl2srow_load  output  3  one-hot load strobe; bit k loads row register k+1 from memory read data.
REQ-015 busy  output  1  high from the cycle after an accepted go through DONE, inclusive.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 cfg_err  output  1  illegal configuration flag, held until the next accepted go.

Function
REQ-018 On go in IDLE, all cfg_* inputs shall be registered; later changes shall have no effect until the next go.
REQ-019 go outside IDLE shall be ignored.
REQ-020 FSM states: IDLE, RD1, RD2, RD3, WR, DONE.
REQ-021 On go in IDLE: next state DONE if cfg_rows<3 or cfg_cols==0; otherwise RD1.
REQ-022 When go leads directly to DONE, cfg_err shall be set and no mem_req shall be issued.
REQ-023 Counters shall be r (output row, 0..rows-3) and c (chunk, 0..cols-1), both cleared on go.
REQ-024 Read addresses shall be RD1 = in_base+r*cols+c, RD2 = RD1+cols, RD3 = RD1+2*cols.
REQ-025 Write address shall be WR = out_base+r*cols+c.
REQ-026 All address arithmetic shall be modulo 2^ADDR_WIDTH.
REQ-027 Addresses shall come from running row-pointer registers advanced by cols per row; no multiplier.
REQ-028 mem_req shall be 1 in RD1/RD2/RD3/WR and 0 elsewhere.
REQ-029 mem_we shall be 1 only in WR.
REQ-030 mem_addr and mem_we shall be held stable while mem_req=1 and mem_ack=0.
REQ-031 Each state shall wait indefinitely for mem_ack; on ack it advances RD1->RD2->RD3->WR, no idle gap.
REQ-032 sctrl2srow_load shall equal {RD3,RD2,RD1} state decode ANDed with mem_ack, combinational, 0 in all other cycles.
REQ-033 WR+ack with c<cols-1: c+1, next RD1.
REQ-034 WR+ack with c==cols-1 and r<rows-3: c=0, r+1, next RD1.
REQ-035 WR+ack with c==cols-1 and r==rows-3: next DONE.
REQ-036 DONE shall assert done=1 for exactly one cycle, then go to IDLE.
REQ-037 Throughput shall be 4 cycles per chunk with mem_ack tied high.
REQ-038 mem_ack outside RD1/RD2/RD3/WR shall be ignored.

Reset
REQ-039 Reset shall force IDLE, r=c=0, and busy, done, cfg_err, mem_req, mem_we, sctrl2srow_load all 0; mem_addr 0.
REQ-040 Reset mid-transaction shall drop mem_req in the same cycle, with no further load strobe and no done pulse.

Verification
REQ-041 in_base=0x100, out_base=0x200, cols=2, rows=3, ack tied 1, go at cycle 0 -> cycles 1-8 addresses 0x100,0x102,0x104,W0x200,0x101,0x103,0x105,W0x201; load 001,010,100 on reads; done=1 cycle 9 only.
REQ-042 rows=2, cols=4, go -> DONE next cycle, done pulse, cfg_err=1, mem_req never high; next legal go clears cfg_err.
REQ-043 ack delayed 3 cycles per request -> mem_addr/mem_we stable while waiting, load strobe only on ack cycle, 16 cycles per chunk.
REQ-044 in_base=0xFFFE, cols=1, rows=4 -> reads 0xFFFE,0xFFFF,0x0000 then 0xFFFF,0x0000,0x0001; 2 writes.
REQ-045 reset asserted in RD2 while mem_ack=0 -> mem_req=0 immediately, IDLE, busy=0; later go runs a full image correctly.
REQ-046 go pulsed while busy and cfg_* changed mid-run -> transaction sequence identical to an undisturbed run.

Source files
------------

// File: rtl/sobel_control_unit.sv
// Sobel control unit: walks an image in memory-word chunks. For every chunk
// it reads three vertically adjacent input words, one per row register, then
// writes one output word. Addresses come from running row pointers, so no
// multiplier is needed.
//
// Memory handshake: mem_req is the valid. mem_ack is the ready/complete
// strobe. A request is in flight while mem_req=1. It completes in the cycle
// where mem_req=1 and mem_ack=1, and read data is valid in that same cycle.
// mem_addr and mem_we do not change while mem_req=1 and mem_ack=0. mem_ack
// has no effect in any cycle where mem_req=0.
module sobel_control_unit #(
   parameter int ADDR_WIDTH = 16,
   parameter int DIM_WIDTH  = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  go,
   input  logic [ADDR_WIDTH-1:0] cfg_in_base,
   input  logic [ADDR_WIDTH-1:0] cfg_out_base,
   input  logic [DIM_WIDTH-1:0]  cfg_cols,
   input  logic [DIM_WIDTH-1:0]  cfg_rows,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   output logic [2:0]            sctrl2srow_load,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err,
   output logic [2:0]            dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD1  = 3'd1,
      S_RD2  = 3'd2,
      S_RD3  = 3'd3,
      S_WR   = 3'd4,
      S_DONE = 3'd5
   } state_t;

   localparam logic [DIM_WIDTH-1:0] DIM_ONE   = DIM_WIDTH'(1);
   localparam logic [DIM_WIDTH-1:0] DIM_THREE = DIM_WIDTH'(3);

   state_t                state, state_next;
   logic [DIM_WIDTH-1:0]  cols_q, rows_q;
   logic [DIM_WIDTH-1:0]  r, c;
   logic [ADDR_WIDTH-1:0] in_row_ptr, out_row_ptr;

   logic                  start;
   logic                  cfg_bad;
   logic                  last_c, last_r;
   logic [ADDR_WIDTH-1:0] cols_ext, c_ext;
   logic [ADDR_WIDTH-1:0] rd1_addr, rd2_addr, rd3_addr, wr_addr;

   assign cfg_bad   = (cfg_rows < DIM_THREE) || (cfg_cols == '0);
   assign last_c    = (c == cols_q - DIM_ONE);
   assign last_r    = (r == rows_q - DIM_THREE);
   assign cols_ext  = ADDR_WIDTH'(cols_q);
   assign c_ext     = ADDR_WIDTH'(c);
   assign rd1_addr  = in_row_ptr + c_ext;
   assign rd2_addr  = rd1_addr + cols_ext;
   assign rd3_addr  = rd1_addr + (cols_ext << 1);
   assign wr_addr   = out_row_ptr + c_ext;
   assign dbg_state = state;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state decode and memory/status outputs
   always_comb begin
      state_next      = state;
      start           = 1'b0;
      mem_req         = 1'b0;
      mem_we          = 1'b0;
      mem_addr        = '0;
      sctrl2srow_load = 3'b000;
      busy            = 1'b1;
      done            = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (go) begin
               start      = 1'b1;
               state_next = cfg_bad ? S_DONE : S_RD1;
            end
         end
         S_RD1: begin
            mem_req         = 1'b1;
            mem_addr        = rd1_addr;
            sctrl2srow_load = {2'b00, mem_ack};
            if (mem_ack) state_next = S_RD2;
         end
         S_RD2: begin
            mem_req         = 1'b1;
            mem_addr        = rd2_addr;
            sctrl2srow_load = {1'b0, mem_ack, 1'b0};
            if (mem_ack) state_next = S_RD3;
         end
         S_RD3: begin
            mem_req         = 1'b1;
            mem_addr        = rd3_addr;
            sctrl2srow_load = {mem_ack, 2'b00};
            if (mem_ack) state_next = S_WR;
         end
         S_WR: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = wr_addr;
            if (mem_ack) state_next = (last_c && last_r) ? S_DONE : S_RD1;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = S_IDLE;
         end
      endcase
   end

   // Configuration capture, chunk/row counters and running row pointers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cols_q      <= '0;
         rows_q      <= '0;
         r           <= '0;
         c           <= '0;
         in_row_ptr  <= '0;
         out_row_ptr <= '0;
         cfg_err     <= 1'b0;
      end else if (start) begin
         cols_q      <= cfg_cols;
         rows_q      <= cfg_rows;
         r           <= '0;
         c           <= '0;
         in_row_ptr  <= cfg_in_base;
         out_row_ptr <= cfg_out_base;
         cfg_err     <= cfg_bad;
      end else if (state == S_WR && mem_ack) begin
         if (!last_c) begin
            c <= c + DIM_ONE;
         end else if (!last_r) begin
            c           <= '0;
            r           <= r + DIM_ONE;
            in_row_ptr  <= in_row_ptr + cols_ext;
            out_row_ptr <= out_row_ptr + cols_ext;
         end
      end
   end

endmodule

// File: tb/tb_sobel_control_unit.sv
// Directed bench for sobel_control_unit: per-cycle vector tables for full
// image walks, plus hand sequences for delayed ack and mid-run reset.
module tb_sobel_control_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        go;
   logic [15:0] cfg_in_base, cfg_out_base;
   logic [11:0] cfg_cols, cfg_rows;
   logic        mem_req, mem_we, mem_ack;
   logic [15:0] mem_addr;
   logic [2:0]  sctrl2srow_load;
   logic        busy, done, cfg_err;
   logic [2:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        go;
      logic        ack;
      logic        req;
      logic        we;
      logic [15:0] addr;
      logic [2:0]  load;
      logic        busy;
      logic        done;
      logic        err;
   } vec_t;

   vec_t        vec [0:15];
   int          n_vec;
   logic [15:0] t_in, t_out;
   logic [11:0] t_cols, t_rows;

   sobel_control_unit #(.ADDR_WIDTH(16), .DIM_WIDTH(12)) dut (
      .clock           (clock),
      .reset           (reset),
      .go              (go),
      .cfg_in_base     (cfg_in_base),
      .cfg_out_base    (cfg_out_base),
      .cfg_cols        (cfg_cols),
      .cfg_rows        (cfg_rows),
      .mem_req         (mem_req),
      .mem_we          (mem_we),
      .mem_addr        (mem_addr),
      .mem_ack         (mem_ack),
      .sctrl2srow_load (sctrl2srow_load),
      .busy            (busy),
      .done            (done),
      .cfg_err         (cfg_err),
      .dbg_state       (dbg_state)
   );

   // Clock
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void set_vec(input int i, input logic g, input logic a,
                                   input logic rq, input logic w, input logic [15:0] ad,
                                   input logic [2:0] ld, input logic b, input logic d,
                                   input logic e);
      vec[i].go = g;   vec[i].ack = a;  vec[i].req = rq; vec[i].we = w;
      vec[i].addr = ad; vec[i].load = ld; vec[i].busy = b; vec[i].done = d;
      vec[i].err = e;
   endfunction

   // Drives one table; after the first entry the cfg inputs are scrambled,
   // which must have no effect on the captured run.
   task automatic apply_vecs(input string tag);
      for (int i = 0; i < n_vec; i++) begin
         @(negedge clock);
         go      = vec[i].go;
         mem_ack = vec[i].ack;
         if (i == 0) begin
            cfg_in_base = t_in;  cfg_out_base = t_out;
            cfg_cols    = t_cols; cfg_rows    = t_rows;
         end else begin
            cfg_in_base = 16'h7777; cfg_out_base = 16'h1234;
            cfg_cols    = 12'd5;    cfg_rows     = 12'd9;
         end
         #1;
         check($sformatf("%s[%0d] req", tag, i), 32'(mem_req), 32'(vec[i].req));
         check($sformatf("%s[%0d] we", tag, i), 32'(mem_we), 32'(vec[i].we));
         if (vec[i].req)
            check($sformatf("%s[%0d] addr", tag, i), 32'(mem_addr), 32'(vec[i].addr));
         check($sformatf("%s[%0d] load", tag, i), 32'(sctrl2srow_load), 32'(vec[i].load));
         check($sformatf("%s[%0d] busy", tag, i), 32'(busy), 32'(vec[i].busy));
         check($sformatf("%s[%0d] done", tag, i), 32'(done), 32'(vec[i].done));
         check($sformatf("%s[%0d] err", tag, i), 32'(cfg_err), 32'(vec[i].err));
      end
      go = 1'b0;
   endtask

   // 3 rows x 2 chunks; a stray go during the run must be ignored
   task automatic build_basic();
      t_in = 16'h0100; t_out = 16'h0200; t_cols = 12'd2; t_rows = 12'd3;
      n_vec = 11;
      set_vec(0,  1, 1, 0, 0, 16'h0000, 3'b000, 0, 0, 0);
      set_vec(1,  0, 1, 1, 0, 16'h0100, 3'b001, 1, 0, 0);
      set_vec(2,  1, 1, 1, 0, 16'h0102, 3'b010, 1, 0, 0);
      set_vec(3,  0, 1, 1, 0, 16'h0104, 3'b100, 1, 0, 0);
      set_vec(4,  1, 1, 1, 1, 16'h0200, 3'b000, 1, 0, 0);
      set_vec(5,  0, 1, 1, 0, 16'h0101, 3'b001, 1, 0, 0);
      set_vec(6,  0, 1, 1, 0, 16'h0103, 3'b010, 1, 0, 0);
      set_vec(7,  1, 1, 1, 0, 16'h0105, 3'b100, 1, 0, 0);
      set_vec(8,  0, 1, 1, 1, 16'h0201, 3'b000, 1, 0, 0);
      set_vec(9,  1, 1, 0, 0, 16'h0000, 3'b000, 1, 1, 0);
      set_vec(10, 0, 1, 0, 0, 16'h0000, 3'b000, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1; go = 1'b0; mem_ack = 1'b0;
      cfg_in_base = '0; cfg_out_base = '0; cfg_cols = '0; cfg_rows = '0;

      // Reset state
      @(negedge clock); #1;
      check("rst req", 32'(mem_req), 32'd0);
      check("rst we", 32'(mem_we), 32'd0);
      check("rst addr", 32'(mem_addr), 32'd0);
      check("rst load", 32'(sctrl2srow_load), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst err", 32'(cfg_err), 32'd0);
      check("rst state", 32'(dbg_state), 32'd0);
      @(negedge clock); reset = 1'b0;

      // Basic 3x2 image, ack tied high
      build_basic();
      apply_vecs("basic");

      // Illegal configuration: rows=2 goes straight to DONE with no requests
      t_in = 16'h0100; t_out = 16'h0200; t_cols = 12'd4; t_rows = 12'd2;
      n_vec = 4;
      set_vec(0, 1, 1, 0, 0, 16'h0000, 3'b000, 0, 0, 0);
      set_vec(1, 0, 1, 0, 0, 16'h0000, 3'b000, 1, 1, 1);
      set_vec(2, 0, 1, 0, 0, 16'h0000, 3'b000, 0, 0, 1);
      set_vec(3, 0, 1, 0, 0, 16'h0000, 3'b000, 0, 0, 1);
      apply_vecs("cfgerr");

      // Address wrap; legal go also clears cfg_err
      t_in = 16'hFFFE; t_out = 16'h0010; t_cols = 12'd1; t_rows = 12'd4;
      n_vec = 11;
      set_vec(0,  1, 1, 0, 0, 16'h0000, 3'b000, 0, 0, 1);
      set_vec(1,  0, 1, 1, 0, 16'hFFFE, 3'b001, 1, 0, 0);
      set_vec(2,  0, 1, 1, 0, 16'hFFFF, 3'b010, 1, 0, 0);
      set_vec(3,  0, 1, 1, 0, 16'h0000, 3'b100, 1, 0, 0);
      set_vec(4,  0, 1, 1, 1, 16'h0010, 3'b000, 1, 0, 0);
      set_vec(5,  0, 1, 1, 0, 16'hFFFF, 3'b001, 1, 0, 0);
      set_vec(6,  0, 1, 1, 0, 16'h0000, 3'b010, 1, 0, 0);
      set_vec(7,  0, 1, 1, 0, 16'h0001, 3'b100, 1, 0, 0);
      set_vec(8,  0, 1, 1, 1, 16'h0011, 3'b000, 1, 0, 0);
      set_vec(9,  0, 1, 0, 0, 16'h0000, 3'b000, 1, 1, 0);
      set_vec(10, 0, 1, 0, 0, 16'h0000, 3'b000, 0, 0, 0);
      apply_vecs("wrap");

      // Delayed ack: each request waits 3 cycles, 16 cycles for one chunk
      @(negedge clock);
      cfg_in_base = 16'h0040; cfg_out_base = 16'h0080; cfg_cols = 12'd1; cfg_rows = 12'd3;
      go = 1'b1; mem_ack = 1'b0;
      @(negedge clock);
      go = 1'b0;
      for (int k = 0; k < 4; k++) begin
         for (int w = 0; w < 4; w++) begin
            if (k > 0 || w > 0) @(negedge clock);
            mem_ack = (w == 3);
            cfg_in_base = 16'h5555;
            #1;
            check($sformatf("slow[%0d.%0d] req", k, w), 32'(mem_req), 32'd1);
            check($sformatf("slow[%0d.%0d] we", k, w), 32'(mem_we), (k == 3) ? 32'd1 : 32'd0);
            check($sformatf("slow[%0d.%0d] addr", k, w), 32'(mem_addr),
                  (k == 3) ? 32'h0080 : 32'h0040 + 32'(k));
            check($sformatf("slow[%0d.%0d] load", k, w), 32'(sctrl2srow_load),
                  (w == 3 && k < 3) ? (32'd1 << k) : 32'd0);
         end
      end
      @(negedge clock); mem_ack = 1'b0; #1;
      check("slow done", 32'(done), 32'd1);
      @(negedge clock); #1;
      check("slow idle busy", 32'(busy), 32'd0);

      // Reset while waiting in RD2
      @(negedge clock);
      cfg_in_base = 16'h0100; cfg_out_base = 16'h0200; cfg_cols = 12'd2; cfg_rows = 12'd3;
      go = 1'b1; mem_ack = 1'b1;
      @(negedge clock); go = 1'b0; mem_ack = 1'b1;
      @(negedge clock); mem_ack = 1'b0; #1;
      check("rd2 req", 32'(mem_req), 32'd1);
      check("rd2 addr", 32'(mem_addr), 32'h0102);
      reset = 1'b1; #1;
      check("midrst req", 32'(mem_req), 32'd0);
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst load", 32'(sctrl2srow_load), 32'd0);
      check("midrst state", 32'(dbg_state), 32'd0);
      @(negedge clock); reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock); #1;
         check($sformatf("postrst[%0d] done", i), 32'(done), 32'd0);
         check($sformatf("postrst[%0d] req", i), 32'(mem_req), 32'd0);
      end

      // Full image after the mid-run reset
      build_basic();
      apply_vecs("rerun");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
